// File: rtl/alu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_sequencer: multi-cycle fetch/decode/execute/writeback controller |
// | that drives an external ALU from a 4x8 register file.  Rev 1.0       |
// +----------------------------------------------------------------------+
module alu_sequencer #(
  parameter int REG_WIDTH = 8,
  parameter int OP_WIDTH  = 4,
  parameter int PC_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic [8:0]           imem_data,
  output logic [REG_WIDTH-1:0] alu_ra,
  output logic [REG_WIDTH-1:0] alu_rb,
  output logic [OP_WIDTH-1:0]  alu_op,
  input  logic [REG_WIDTH-1:0] alu_res,
  input  logic [REG_WIDTH-1:0] alu_car,
  input  logic                 alu_zero,
  input  logic                 alu_branch,
  output logic [REG_WIDTH-1:0] carry_q,
  output logic                 zero_q,
  output logic                 busy,
  output logic                 retired,
  output logic                 done,
  input  logic [1:0]           dbg_sel,
  output logic [REG_WIDTH-1:0] dbg_data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [8:0]           r_ir;
  logic [PC_WIDTH-1:0]  r_pc;
  logic [REG_WIDTH-1:0] r_regs [4];
  logic [REG_WIDTH-1:0] r_res;
  logic [REG_WIDTH-1:0] r_car;
  logic                 r_zero;
  logic                 r_branch;
  logic [REG_WIDTH-1:0] r_target;
  logic                 r_done;

  logic [3:0]           w_op;
  logic [1:0]           w_ra;
  logic [1:0]           w_rb;
  logic [REG_WIDTH-1:0] w_imm_ext;
  logic                 w_is_alu_wr;
  logic                 w_is_carry;
  logic                 w_is_beq;
  logic                 w_is_movi;
  logic                 w_is_halt;

  assign w_op      = r_ir[8:5];
  assign w_ra      = r_ir[4:3];
  assign w_rb      = r_ir[2:1];
  assign w_imm_ext = {{(REG_WIDTH-3){r_ir[2]}}, r_ir[2:0]};

  // Ops 0-6 and 8-10 write the ALU result and the zero flag.
  assign w_is_alu_wr = (w_op <= 4'd6) || ((w_op >= 4'd8) && (w_op <= 4'd10));
  assign w_is_carry  = (w_op == 4'd4) || (w_op == 4'd5) ||
                       ((w_op >= 4'd8) && (w_op <= 4'd10));
  assign w_is_beq    = (w_op == 4'd7);
  assign w_is_movi   = (w_op == 4'd11);
  assign w_is_halt   = (w_op == 4'd15);

  assign imem_addr = r_pc;
  assign busy      = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                     (r_state == S_EXEC)  || (r_state == S_WB);
  assign retired   = (r_state == S_WB);
  assign done      = r_done;
  assign dbg_data  = r_regs[dbg_sel];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_HALT: if (start) w_next = S_FETCH;
      S_FETCH:        w_next = S_DECODE;
      S_DECODE:       w_next = w_is_halt ? S_HALT : S_EXEC;
      S_EXEC:         w_next = S_WB;
      S_WB:           w_next = S_FETCH;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc     <= '0;
      r_ir     <= '0;
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
      r_res    <= '0;
      r_car    <= '0;
      r_zero   <= 1'b0;
      r_branch <= 1'b0;
      r_target <= '0;
      r_done   <= 1'b0;
      carry_q  <= '0;
      zero_q   <= 1'b0;
      alu_ra   <= '0;
      alu_rb   <= '0;
      alu_op   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE, S_HALT: if (start) r_pc <= '0;
        S_FETCH: r_ir <= imem_data;
        S_DECODE: begin
          r_target <= r_regs[3];
          if (w_is_halt) begin
            r_done <= 1'b1;
          end else if (!w_is_movi) begin
            // MOV routes its source (rb) through operand A.
            alu_op <= OP_WIDTH'(w_op);
            alu_ra <= (w_op == 4'd6) ? r_regs[w_rb] : r_regs[w_ra];
            alu_rb <= r_regs[w_rb];
          end
        end
        S_EXEC: begin
          r_res    <= alu_res;
          r_car    <= alu_car;
          r_zero   <= alu_zero;
          r_branch <= alu_branch;
        end
        S_WB: begin
          r_pc <= r_pc + PC_WIDTH'(1);
          if (w_is_alu_wr) begin
            r_regs[w_ra] <= r_res;
            zero_q       <= r_zero;
          end
          if (w_is_carry) carry_q <= r_car;
          if (w_is_movi) r_regs[w_ra] <= w_imm_ext;
          if (w_is_beq && r_branch) r_pc <= PC_WIDTH'(r_target);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// Self-checking bench for alu_sequencer: ALU stub, ROM array and an
// instruction-level reference model compared every falling edge.
`timescale 1ns/1ps
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] imem_addr;
  logic [8:0] imem_data;
  logic [7:0] alu_ra, alu_rb;
  logic [3:0] alu_op;
  logic [7:0] alu_res, alu_car;
  logic       alu_zero, alu_branch;
  logic [7:0] carry_q;
  logic       zero_q, busy, retired, done;
  logic [1:0] dbg_sel = 2'd0;
  logic [7:0] dbg_data;

  logic [8:0] rom [256];
  int checks = 0;
  int errors = 0;

  localparam logic [8:0] HALT = 9'h1E0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .alu_ra(alu_ra), .alu_rb(alu_rb), .alu_op(alu_op),
    .alu_res(alu_res), .alu_car(alu_car), .alu_zero(alu_zero), .alu_branch(alu_branch),
    .carry_q(carry_q), .zero_q(zero_q), .busy(busy), .retired(retired), .done(done),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // ALU stub; non-carry ops drive deliberate garbage on car.
  function automatic logic [17:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0]  w;
    logic [15:0] m;
    logic [7:0]  r, c;
    r = '0;
    c = a ^ b ^ 8'h5A;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a ^ b;
      4'd3: r = {7'd0, ($signed(a) < $signed(b))};
      4'd4: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = {7'd0, w[8]}; end
      4'd5: begin r = a - b; c = {7'd0, (a < b)}; end
      4'd6: r = a;
      4'd7: r = a - b;
      4'd8: begin r = {a[6:0], 1'b0}; c = {7'd0, a[7]}; end
      4'd9: begin r = {1'b0, a[7:1]}; c = {7'd0, a[0]}; end
      4'd10: begin m = a * b; r = m[7:0]; c = m[15:8]; end
      default: r = '0;
    endcase
    return {r, c, (r == 8'd0), (a == b)};
  endfunction

  assign imem_data = rom[imem_addr];
  assign {alu_res, alu_car, alu_zero, alu_branch} = alu_fn(alu_op, alu_ra, alu_rb);

  function automatic logic [8:0] ins(input int op, input int ra, input int rb);
    logic [3:0] o; logic [1:0] a, b;
    o = 4'(op); a = 2'(ra); b = 2'(rb);
    return {o, a, b, 1'b0};
  endfunction

  function automatic logic [8:0] movi(input int ra, input logic [2:0] imm);
    logic [1:0] a;
    a = 2'(ra);
    return {4'd11, a, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural reference model
  logic [7:0] m_reg [4];
  logic [7:0] m_c, m_pc, m_ara, m_arb;
  logic [3:0] m_aop;
  logic       m_z, m_run;
  int         m_age;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = '0;
    m_c = '0; m_z = 1'b0; m_pc = '0; m_run = 1'b0; m_age = 0;
    m_aop = '0; m_ara = '0; m_arb = '0;
  endtask

  task automatic iss_step(input logic [8:0] iw);
    logic [3:0] op; logic [1:0] ra; logic [17:0] f; logic [7:0] npc;
    op  = iw[8:5];
    ra  = iw[4:3];
    f   = alu_fn(op, m_ara, m_arb);
    npc = m_pc + 8'd1;
    if (op <= 4'd6 || (op >= 4'd8 && op <= 4'd10)) begin
      m_reg[ra] = f[17:10];
      m_z = f[1];
    end
    if (op == 4'd4 || op == 4'd5 || (op >= 4'd8 && op <= 4'd10)) m_c = f[9:2];
    if (op == 4'd7 && f[0]) npc = m_reg[3];
    if (op == 4'd11) m_reg[ra] = {{5{iw[2]}}, iw[2:0]};
    m_pc = npc;
  endtask

  always @(negedge clk) begin : cmp
    logic [8:0] iw;
    logic [3:0] op;
    logic eb, er, ed;
    eb = 1'b0; er = 1'b0; ed = 1'b0;
    if (reset) model_reset();
    iw = rom[m_pc];
    op = iw[8:5];
    if (!reset && m_run) begin
      m_age++;
      if (op == 4'd15) begin eb = (m_age <= 2); ed = (m_age == 3); end
      else begin eb = 1'b1; er = (m_age == 4); end
    end
    chk("busy", busy, eb);
    chk("retired", retired, er);
    chk("done", done, ed);
    chk("imem_addr", imem_addr, m_pc);
    chk("carry_q", carry_q, m_c);
    chk("zero_q", zero_q, m_z);
    chk("dbg_data", dbg_data, m_reg[dbg_sel]);
    chk("alu_op", alu_op, m_aop);
    chk("alu_ra", alu_ra, m_ara);
    chk("alu_rb", alu_rb, m_arb);
    if (!reset) begin
      if (m_run && m_age == 2 && op != 4'd15 && op != 4'd11) begin
        m_aop = op;
        m_ara = (op == 4'd6) ? m_reg[iw[2:1]] : m_reg[iw[4:3]];
        m_arb = m_reg[iw[2:1]];
      end
      if (m_run && op == 4'd15 && m_age == 3) m_run = 1'b0;
      if (er) begin iss_step(iw); m_age = 0; end
      if (!m_run && start) begin m_run = 1'b1; m_age = 0; m_pc = '0; end
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = HALT;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Runs until done; optionally raises start for one cycle at iteration spur.
  task automatic run_prog(input int spur, output int nret);
    int n;
    logic hit;
    nret = 0; hit = 1'b0; n = 0;
    pulse_start();
    while (!hit && n < 400) begin
      @(negedge clk);
      if (retired) nret++;
      if (done) hit = 1'b1;
      #1;
      start = (n == spur);
      dbg_sel = dbg_sel + 2'd1;
      n++;
    end
    start = 1'b0;
    chk("done_timeout", {31'd0, hit}, 32'd1);
    @(negedge clk); #2;
  endtask

  task automatic peek(input string name, input int sel, input logic [7:0] exp);
    dbg_sel = 2'(sel);
    #1 chk(name, dbg_data, exp);
  endtask

  initial begin
    int nret;
    int n;
    clear_rom();
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_dbg", dbg_data, 0);
    @(negedge clk); #2 reset = 1'b0;

    // ADD with carry out
    rom[0] = movi(0, 3'b011); rom[1] = movi(1, 3'b110); rom[2] = ins(4, 0, 1); rom[3] = HALT;
    run_prog(5, nret);
    chk("A_retired_count", nret, 3);
    peek("A_r0", 0, 8'h01);
    chk("A_carry", carry_q, 8'h01);
    chk("A_zero", zero_q, 0);
    chk("A_busy_after", busy, 0);

    // r3 = 6 for the branch tests
    clear_rom();
    rom[0] = movi(3, 3'b011); rom[1] = ins(4, 3, 3);
    run_prog(-1, nret);
    peek("S1_r3", 3, 8'h06);

    rom[0] = movi(0, 3'b010); rom[1] = movi(1, 3'b010); rom[2] = ins(12, 0, 0);
    rom[3] = ins(7, 0, 1);
    run_prog(-1, nret);
    chk("B_taken_pc", imem_addr, 8'h06);

    rom[1] = movi(1, 3'b001);
    run_prog(-1, nret);
    chk("B_nottaken_pc", imem_addr, 8'h04);

    // SUB then signed SLT
    clear_rom();
    rom[0] = movi(0, 3'b111); rom[1] = movi(1, 3'b001); rom[2] = ins(5, 0, 1);
    rom[3] = ins(3, 1, 0);
    run_prog(-1, nret);
    peek("C_r0", 0, 8'hFE);
    peek("C_r1", 1, 8'h00);
    chk("C_carry", carry_q, 8'h00);
    chk("C_zero", zero_q, 1);

    // Branch to 253, NOPs through 255, wrap to 0
    clear_rom();
    rom[0] = movi(1, 3'b110);
    run_prog(-1, nret);
    rom[0] = movi(3, 3'b101); rom[1] = ins(7, 0, 1); rom[2] = HALT;
    rom[253] = movi(1, 3'b011); rom[254] = ins(13, 0, 0); rom[255] = ins(14, 2, 3);
    run_prog(6, nret);
    chk("D_retired_count", nret, 7);
    chk("D_halt_pc", imem_addr, 8'h02);
    peek("D_r1", 1, 8'h03);

    // Asynchronous reset in the middle of an ADD
    clear_rom();
    rom[0] = movi(0, 3'b001); rom[1] = ins(4, 0, 0);
    pulse_start();
    n = 0;
    while (!retired && n < 20) begin @(negedge clk); n++; end
    chk("E_wait_retire", {31'd0, retired}, 32'd1);
    repeat (3) @(negedge clk);
    chk("E_exec_op", alu_op, 4'd4);
    dbg_sel = 2'd0;
    #2 reset = 1'b1;
    #1;
    chk("E_rst_busy", busy, 0);
    chk("E_rst_pc", imem_addr, 0);
    chk("E_rst_ra", alu_ra, 0);
    chk("E_rst_op", alu_op, 0);
    chk("E_rst_zero", zero_q, 0);
    chk("E_rst_r0", dbg_data, 0);
    @(negedge clk); #2 reset = 1'b0;
    run_prog(-1, nret);
    chk("E_rerun_retired", nret, 2);
    peek("E_r0", 0, 8'h02);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
